// File: rtl/text_pixel_serializer_if.sv
// Pixel-path bundle between the text generator / font ROM and the serializer.
// Combinational wiring only, no latency of its own.
// No backpressure: one pixel per clock, always accepted.
//
// master: the upstream side (sync generator, text generator, font ROM) and the VGA sink.
// slave : the serializer, which consumes the pixel inputs and drives rgb and the syncs.
interface text_pixel_serializer_if;
  logic       video_on;     // visible-area flag, aligned with pixel_x
  logic       hsync_in;     // horizontal sync, aligned with pixel_x
  logic       vsync_in;     // vertical sync, active high, aligned with pixel_x
  logic [9:0] pixel_x;      // pixel column, same cycle the ROM address is issued
  logic       text_on;      // pixel lies inside a character cell
  logic [7:0] font_word;    // font row, valid ROM_LAT cycles after its address
  logic       blink_en;     // allow blinking of lit text pixels
  logic [2:0] rgb;          // pixel colour
  logic       hsync_out;    // hsync aligned with rgb
  logic       vsync_out;    // vsync aligned with rgb
  logic       blink_phase;  // 1 = text currently hidden when blinking

  modport master (
    output video_on, hsync_in, vsync_in, pixel_x, text_on, font_word, blink_en,
    input  rgb, hsync_out, vsync_out, blink_phase
  );

  modport slave (
    input  video_on, hsync_in, vsync_in, pixel_x, text_on, font_word, blink_en,
    output rgb, hsync_out, vsync_out, blink_phase
  );
endinterface

// File: rtl/text_pixel_serializer.sv
// Turns font-ROM rows into per-pixel RGB with fg/bg colours and a frame-counted blink.
// Latency ROM_LAT+1 clocks from pixel_x/video_on/syncs to rgb/hsync_out/vsync_out.
// No backpressure: one pixel per clock, no stalls.
//
// Ports: clk (pixel clock), reset (async, active high), px (slave side of
// text_pixel_serializer_if: pixel position/flags/syncs/font row in, rgb/syncs/blink_phase out).
module text_pixel_serializer #(
  parameter int         ROM_LAT      = 1,       // font ROM read latency, 1..4
  parameter logic [2:0] FG_RGB       = 3'b111,  // lit font pixel colour
  parameter logic [2:0] BG_RGB       = 3'b000,  // unlit pixel colour inside a text cell
  parameter int         BLINK_FRAMES = 30       // frames per blink half-period, 1..255
) (
  input  logic                   clk,
  input  logic                   reset,
  text_pixel_serializer_if.slave px
);

  // Per-pixel attributes that must travel alongside the ROM lookup.
  typedef struct packed {
    logic [2:0] col;
    logic       text_on;
    logic       video_on;
    logic       hsync;
    logic       vsync;
  } tap_t;

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  tap_t [ROM_LAT-1:0] pipe;
  tap_t               aligned;
  logic [2:0]         bit_idx;
  logic               pix;

  logic               vsync_q;
  logic               vsync_rise;
  logic [7:0]         frame_cnt;
  logic               blink_phase_q;

  logic [2:0]         rgb_q;
  logic               hsync_q;
  logic               vsync_d;

  // Only the column within the cell matters here; the upper bits address the ROM upstream.
  logic               unused_x;
  assign unused_x = ^px.pixel_x[9:3];

  // Last delay stage lines up with the font row returned for the same pixel.
  assign aligned = pipe[ROM_LAT-1];

  // Bit 7 is the leftmost column of the cell; 3-bit arithmetic cannot overflow.
  assign bit_idx = 3'd7 - aligned.col;
  assign pix     = px.font_word[bit_idx];

  assign vsync_rise = px.vsync_in & ~vsync_q;

  // Attribute delay line, depth ROM_LAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= {px.pixel_x[2:0], px.text_on, px.video_on, px.hsync_in, px.vsync_in};
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Colour select. blink_en is taken live (not delayed) and blink_phase is the value
  // before any toggle happening on this same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 3'b000;
      hsync_q <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      if (!aligned.video_on || !aligned.text_on) begin
        rgb_q <= 3'b000;
      end else if (pix && !(px.blink_en && blink_phase_q)) begin
        rgb_q <= FG_RGB;
      end else begin
        rgb_q <= BG_RGB;
      end
      hsync_q <= aligned.hsync;
      vsync_d <= aligned.vsync;
    end
  end

  // Frame counter on undelayed vsync rising edges. The edge register clears on reset,
  // so vsync_in already high at release counts as one edge. Runs regardless of blink_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      frame_cnt     <= 8'd0;
      blink_phase_q <= 1'b0;
    end else begin
      vsync_q <= px.vsync_in;
      if (vsync_rise) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt     <= 8'd0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign px.rgb         = rgb_q;
  assign px.hsync_out   = hsync_q;
  assign px.vsync_out   = vsync_d;
  assign px.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Bench for text_pixel_serializer: two instances (ROM_LAT=1 and ROM_LAT=3, BLINK_FRAMES=3)
// share one stimulus stream; a behavioural font ROM delays each pixel's row per instance.
// Expected outputs go to a per-instance queue at drive time and are popped when due.
module tb_text_pixel_serializer;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b010;
  localparam int         BF = 3;

  typedef struct {
    logic       vid;
    logic       txt;
    logic       hs;
    logic       vs;
    logic       ben;
    logic [9:0] x;
    logic [7:0] row;
    logic [2:0] exp;
  } rec_t;

  typedef struct {
    int         due;
    int         tag;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   edges;
  logic prev_vs;
  logic cur_ben;

  logic [7:0] row_hist [0:4095];
  exp_t       q1 [$];
  exp_t       q3 [$];
  rec_t       tbl [21];

  text_pixel_serializer_if if1 ();
  text_pixel_serializer_if if3 ();

  text_pixel_serializer #(
    .ROM_LAT(1), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
  ) u_dut1 (
    .clk(clk), .reset(reset), .px(if1)
  );

  text_pixel_serializer #(
    .ROM_LAT(3), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
  ) u_dut3 (
    .clk(clk), .reset(reset), .px(if3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s tag=%0d got=%h want=%h (cycle %0d)", nm, tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin : chk_blk
    exp_t e;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      check("lat1 rgb",       e.tag, {5'd0, if1.rgb},       {5'd0, e.rgb});
      check("lat1 hsync_out", e.tag, {7'd0, if1.hsync_out}, {7'd0, e.hs});
      check("lat1 vsync_out", e.tag, {7'd0, if1.vsync_out}, {7'd0, e.vs});
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e = q3.pop_front();
      check("lat3 rgb",       e.tag, {5'd0, if3.rgb},       {5'd0, e.rgb});
      check("lat3 hsync_out", e.tag, {7'd0, if3.hsync_out}, {7'd0, e.hs});
      check("lat3 vsync_out", e.tag, {7'd0, if3.vsync_out}, {7'd0, e.vs});
    end
  end

  function automatic rec_t mk(input logic vid, input logic txt, input logic hs, input logic vs,
                              input logic ben, input int x, input logic [7:0] row,
                              input logic [2:0] exp);
    rec_t r;
    r.vid = vid; r.txt = txt; r.hs = hs; r.vs = vs; r.ben = ben;
    r.x = 10'(x); r.row = row; r.exp = exp;
    return r;
  endfunction

  // Applies one pixel for one clock and queues its expected outputs for both instances.
  task automatic drive(input rec_t r, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (r.vs && !prev_vs) edges++;
    prev_vs = r.vs;
    row_hist[cyc] = r.row;
    if1.video_on = r.vid; if3.video_on = r.vid;
    if1.text_on  = r.txt; if3.text_on  = r.txt;
    if1.hsync_in = r.hs;  if3.hsync_in = r.hs;
    if1.vsync_in = r.vs;  if3.vsync_in = r.vs;
    if1.blink_en = r.ben; if3.blink_en = r.ben;
    if1.pixel_x  = r.x;   if3.pixel_x  = r.x;
    if1.font_word = (cyc >= 1) ? row_hist[cyc-1] : 8'h00;
    if3.font_word = (cyc >= 3) ? row_hist[cyc-3] : 8'h00;
    e.tag = tag; e.rgb = r.exp; e.hs = r.hs; e.vs = r.vs;
    e.due = cyc + 2; q1.push_back(e);
    e.due = cyc + 4; q3.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 0, cur_ben, 0, 8'h00, 3'b000), 900);
  endtask

  // One frame: gap, vsync pulse (blink_en changes here), then a run of lit text pixels.
  task automatic frame(input logic ben, input int npix, input int f);
    logic       ph;
    logic [2:0] want;
    idle(3);
    cur_ben = ben;
    for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 1, cur_ben, 0, 8'h00, 3'b000), 1000 + f);
    ph   = ((edges / BF) % 2) == 1;
    want = (ben && ph) ? BG : FG;
    for (int i = 0; i < npix; i++) drive(mk(1, 1, 0, 0, cur_ben, 8 * f + i, 8'hFF, want), 1000 + f);
    check("lat1 blink_phase", 1000 + f, {7'd0, if1.blink_phase}, {7'd0, ph});
    check("lat3 blink_phase", 1000 + f, {7'd0, if3.blink_phase}, {7'd0, ph});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; edges = 0; prev_vs = 1'b0; cur_ben = 1'b0;
    for (int i = 0; i < 4096; i++) row_hist[i] = 8'h00;
    reset = 1'b1;
    if1.video_on = 0; if1.text_on = 0; if1.hsync_in = 0; if1.vsync_in = 0;
    if1.blink_en = 0; if1.pixel_x = '0; if1.font_word = '0;
    if3.video_on = 0; if3.text_on = 0; if3.hsync_in = 0; if3.vsync_in = 0;
    if3.blink_en = 0; if3.pixel_x = '0; if3.font_word = '0;

    // Latency (ROM row 80 on columns 0/1), bit order (A5 over 8..15), blanking, sync pulses.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  8'h00, 3'b000);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,  8'h00, 3'b000);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0,  8'h80, FG);
    tbl[3]  = mk(1, 1, 0, 0, 0, 1,  8'h80, BG);
    tbl[4]  = mk(0, 0, 0, 0, 0, 2,  8'h00, 3'b000);
    tbl[5]  = mk(1, 1, 0, 0, 0, 8,  8'hA5, FG);
    tbl[6]  = mk(1, 1, 0, 0, 0, 9,  8'hA5, BG);
    tbl[7]  = mk(1, 1, 0, 0, 0, 10, 8'hA5, FG);
    tbl[8]  = mk(1, 1, 0, 0, 0, 11, 8'hA5, BG);
    tbl[9]  = mk(1, 1, 0, 0, 0, 12, 8'hA5, BG);
    tbl[10] = mk(1, 1, 0, 0, 0, 13, 8'hA5, FG);
    tbl[11] = mk(1, 1, 0, 0, 0, 14, 8'hA5, BG);
    tbl[12] = mk(1, 1, 0, 0, 0, 15, 8'hA5, FG);
    tbl[13] = mk(0, 1, 1, 0, 0, 16, 8'hFF, 3'b000);
    tbl[14] = mk(0, 1, 1, 0, 0, 17, 8'hFF, 3'b000);
    tbl[15] = mk(0, 1, 1, 0, 0, 18, 8'hFF, 3'b000);
    tbl[16] = mk(1, 0, 0, 0, 0, 19, 8'hFF, 3'b000);
    tbl[17] = mk(1, 0, 0, 0, 0, 20, 8'hFF, 3'b000);
    tbl[18] = mk(0, 0, 0, 1, 0, 0,  8'h00, 3'b000);
    tbl[19] = mk(0, 0, 0, 1, 0, 0,  8'h00, 3'b000);
    tbl[20] = mk(0, 0, 0, 0, 0, 0,  8'h00, 3'b000);

    // Reset state, held through the first clock edges.
    idle(1);
    check("reset lat1 rgb",         0, {5'd0, if1.rgb},         8'h00);
    check("reset lat3 rgb",         0, {5'd0, if3.rgb},         8'h00);
    check("reset lat1 hsync_out",   0, {7'd0, if1.hsync_out},   8'h00);
    check("reset lat3 vsync_out",   0, {7'd0, if3.vsync_out},   8'h00);
    check("reset lat1 blink_phase", 0, {7'd0, if1.blink_phase}, 8'h00);
    check("reset lat3 blink_phase", 0, {7'd0, if3.blink_phase}, 8'h00);
    idle(1);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 21; i++) drive(tbl[i], i);

    // Blink: phase flips every BF vsync rising edges; blink_en only gates the hide.
    for (int f = 1; f <= 6; f++) frame(1'b1, 4, f);
    for (int f = 7; f <= 8; f++) frame(1'b0, 4, f);

    // Reset in the middle of lit pixels with syncs high and blink_phase set.
    for (int i = 0; i < 6; i++) drive(mk(1, 1, 1, 1, cur_ben, i, 8'hFF, FG), 2000);
    #2;
    check("pre-reset lat1 rgb",         2000, {5'd0, if1.rgb},         {5'd0, FG});
    check("pre-reset lat3 rgb",         2000, {5'd0, if3.rgb},         {5'd0, FG});
    check("pre-reset lat3 hsync_out",   2000, {7'd0, if3.hsync_out},   8'h01);
    check("pre-reset lat1 vsync_out",   2000, {7'd0, if1.vsync_out},   8'h01);
    check("pre-reset lat1 blink_phase", 2000, {7'd0, if1.blink_phase}, 8'h01);
    reset = 1'b1;
    #1;
    check("async reset lat1 rgb",         2001, {5'd0, if1.rgb},         8'h00);
    check("async reset lat3 rgb",         2001, {5'd0, if3.rgb},         8'h00);
    check("async reset lat1 hsync_out",   2001, {7'd0, if1.hsync_out},   8'h00);
    check("async reset lat3 hsync_out",   2001, {7'd0, if3.hsync_out},   8'h00);
    check("async reset lat1 vsync_out",   2001, {7'd0, if1.vsync_out},   8'h00);
    check("async reset lat3 vsync_out",   2001, {7'd0, if3.vsync_out},   8'h00);
    check("async reset lat1 blink_phase", 2001, {7'd0, if1.blink_phase}, 8'h00);
    check("async reset lat3 blink_phase", 2001, {7'd0, if3.blink_phase}, 8'h00);
    check("async reset lat1 frame_cnt",   2001, u_dut1.frame_cnt,        8'h00);
    check("async reset lat3 frame_cnt",   2001, u_dut3.frame_cnt,        8'h00);
    q1.delete();
    q3.delete();
    edges   = 0;
    prev_vs = 1'b0;
    cur_ben = 1'b0;
    idle(2);
    reset = 1'b0;

    // Pipeline refills from zero; latency stimulus again after release.
    for (int i = 0; i < 5; i++) drive(tbl[i], 3000 + i);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
